pattern_detector: RTL and testbench
===================================

PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 SHALL provide parameter PAT_LEN, default 4, pattern length in bits (legal 2..16).
REQ-002 SHALL provide parameter PATTERN, default 4'b0110, target pattern; bit PAT_LEN-1 is matched first.
REQ-003 SHALL provide parameter OVERLAP, default 1; 1 = overlapping detection, 0 = non-overlapping.
REQ-004 SHALL provide parameter CNT_W, default 8, match counter width (legal 1..32).
REQ-005 SHALL have port Clock  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port en  input  1  sample qualifier; x is consumed only when en=1.
REQ-008 SHALL have port x  input  1  serial data bit.
REQ-009 SHALL have port clr  input  1  synchronous clear of match_cnt.
REQ-010 SHALL have port z  output  1  Mealy match flag, combinational from state, en and x.
REQ-011 SHALL have port z_q  output  1  registered copy of z, one cycle later.
REQ-012 SHALL have port match_cnt  output  CNT_W  number of matches since reset/clr.

Function
REQ-013 SHALL keep a history of the most recent accepted bits plus a fill count 0..PAT_LEN-1 (or an equivalent prefix-state FSM with identical outputs).
REQ-014 SHALL assert z in a cycle iff en=1, fill count = PAT_LEN-1, and the last PAT_LEN-1 history bits followed by x equal PATTERN.
REQ-015 SHALL never match before PAT_LEN bits have been accepted since reset or since the last non-overlap match (no match on reset-zeroed history).
REQ-016 SHALL leave history, fill count and outputs other than z unchanged when en=0; z SHALL be 0 when en=0.
REQ-017 SHALL, with OVERLAP=1, retain history after a match so the trailing bits can begin the next match.
REQ-018 SHALL, with OVERLAP=0, clear fill count on the edge that accepts a matching bit, requiring PAT_LEN fresh bits.
REQ-019 SHALL update z_q <= z on every rising edge.
REQ-020 SHALL increment match_cnt by 1 on each edge where z=1, saturating at 2^CNT_W-1 (no wrap).
REQ-021 SHALL clear match_cnt to 0 on an edge where clr=1; clr SHALL take priority over a simultaneous match increment.
REQ-022 SHALL not affect history, fill count or z_q via clr.
REQ-023 SHALL produce z with zero-cycle latency relative to the completing bit and match_cnt/z_q with one-cycle latency.

Reset
REQ-024 SHALL, while Reset_n=0, force history=0, fill count=0, z_q=0, match_cnt=0 immediately, independent of Clock.
REQ-025 SHALL force z=0 while Reset_n=0.
REQ-026 SHALL, on reset mid-pattern, discard all partial progress; detection restarts from an empty history.
REQ-027 SHALL resume normal operation on the first rising edge after Reset_n deasserts.

Configuration
REQ-028 SHALL compile match_cnt logic only when macro PATTERN_DETECTOR_CNT_EN is defined.
REQ-029 SHALL, without PATTERN_DETECTOR_CNT_EN, keep port match_cnt present but tied to 0 and ignore clr; z and z_q behaviour SHALL be unchanged.

Verification
REQ-030 SHALL test defaults, en=1, x=0,1,1,0,1,1,0 -> z=1 on bits 4 and 7 only; match_cnt=2 after bit 7.
REQ-031 SHALL test OVERLAP=0, x=0,1,1,0,1,1,0,0,1,1,0 -> z=1 on bits 4 and 11 only; match_cnt=2.
REQ-032 SHALL test PATTERN=4'b0000 after reset, x=0,0,0,0,0 -> z=0 on bits 1-3, z=1 on bits 4 and 5 (OVERLAP=1).
REQ-033 SHALL test en gaps: x=0,1 (en=1), three cycles en=0 with x=1, then x=1,0 (en=1) -> single z=1 on final bit.
REQ-034 SHALL test reset mid-operation: x=0,1,1, pulse Reset_n low asynchronously, x=0 -> z=0; match_cnt=0.
REQ-035 SHALL test CNT_W=2 with 5 matches -> match_cnt saturates at 3; clr coincident with 6th match -> match_cnt=0.

Source files
------------

// File: rtl/pattern_detector.sv
// Serial bit-pattern detector with Mealy match flag, registered copy and match counter.
// The match counter is built only when PATTERN_DETECTOR_CNT_EN is defined; otherwise match_cnt reads 0.
module pattern_detector #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b0110,
    parameter int                 OVERLAP = 1,
    parameter int                 CNT_W   = 8
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             en,
    input  logic             x,
    input  logic             clr,
    output logic             z,
    output logic             z_q,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int             FW   = $clog2(PAT_LEN);
    localparam logic [FW-1:0]  LAST = FW'(PAT_LEN - 1);

    logic [PAT_LEN-2:0] history_q, history_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic               z_q_d;
    logic [PAT_LEN-1:0] window;

    always_comb begin
        window    = {history_q, x};
        z         = Reset_n && en && (fill_q == LAST) && (window == PATTERN);
        history_d = history_q;
        fill_d    = fill_q;
        z_q_d     = z;
        if (en) begin
            history_d = window[PAT_LEN-2:0];
            // Non-overlapping mode demands a full set of fresh bits after each hit.
            if (z && (OVERLAP == 0)) begin
                fill_d = '0;
            end else if (fill_q != LAST) begin
                fill_d = fill_q + FW'(1);
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            history_q <= '0;
            fill_q    <= '0;
            z_q       <= 1'b0;
        end else begin
            history_q <= history_d;
            fill_q    <= fill_d;
            z_q       <= z_q_d;
        end
    end

`ifdef PATTERN_DETECTOR_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        // Clear wins over a coincident hit; the count saturates instead of wrapping.
        if (clr) begin
            cnt_d = '0;
        end else if (z && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    logic unused_clr;
    assign unused_clr = clr;
    assign match_cnt  = '0;
`endif

endmodule

// File: tb/tb_pattern_detector.sv
// Directed bench for pattern_detector: four parameterisations share one stimulus bus,
// each test only inspects the instance it targets.
module tb_pattern_detector;

    logic Clock = 1'b0;
    logic Reset_n;
    logic en;
    logic x;
    logic clr;

    logic       z_w   [4];
    logic       z_q_w [4];
    logic [7:0] cnt_w [4];
    logic [7:0] cnt0, cnt1, cnt2;
    logic [1:0] cnt3;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 Clock = ~Clock;

    pattern_detector u_def (
        .Clock(Clock), .Reset_n(Reset_n), .en(en), .x(x), .clr(clr),
        .z(z_w[0]), .z_q(z_q_w[0]), .match_cnt(cnt0)
    );

    pattern_detector #(.OVERLAP(0)) u_nov (
        .Clock(Clock), .Reset_n(Reset_n), .en(en), .x(x), .clr(clr),
        .z(z_w[1]), .z_q(z_q_w[1]), .match_cnt(cnt1)
    );

    pattern_detector #(.PATTERN(4'b0000)) u_zero (
        .Clock(Clock), .Reset_n(Reset_n), .en(en), .x(x), .clr(clr),
        .z(z_w[2]), .z_q(z_q_w[2]), .match_cnt(cnt2)
    );

    pattern_detector #(.CNT_W(2)) u_sat (
        .Clock(Clock), .Reset_n(Reset_n), .en(en), .x(x), .clr(clr),
        .z(z_w[3]), .z_q(z_q_w[3]), .match_cnt(cnt3)
    );

    assign cnt_w[0] = cnt0;
    assign cnt_w[1] = cnt1;
    assign cnt_w[2] = cnt2;
    assign cnt_w[3] = {6'b0, cnt3};

    // Counter values only exist in the counter-enabled build.
    function automatic logic [31:0] exp_cnt(input logic [31:0] v);
`ifdef PATTERN_DETECTOR_CNT_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One sample: drive at negedge, check Mealy z before the edge, z_q after it.
    task automatic apply(input int inst, input logic e, input logic xi, input logic ci,
                         input logic ez, input string tag);
        @(negedge Clock);
        en  = e;
        x   = xi;
        clr = ci;
        #1;
        check($sformatf("%s z", tag), {31'd0, z_w[inst]}, {31'd0, ez});
        @(posedge Clock);
        #1;
        check($sformatf("%s z_q", tag), {31'd0, z_q_w[inst]}, {31'd0, ez});
        $display("%s inst=%0d en=%0b x=%0b clr=%0b z_exp=%0b cnt=%0d", tag, inst, e, xi, ci, ez, cnt_w[inst]);
    endtask

    task automatic run_seq(input int inst, input int n, input logic [31:0] xs,
                           input logic [31:0] zs, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            apply(inst, 1'b1, xs[i], 1'b0, zs[i], $sformatf("%s bit%0d", tag, n - i));
        end
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset_n = 1'b0;
        en  = 1'b0;
        clr = 1'b0;
        @(negedge Clock);
        Reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        Reset_n = 1'b0;
        en  = 1'b1;
        x   = 1'b0;
        clr = 1'b0;
        #12;
        // Reset state with en=1, x=0: the all-zero pattern must not fire on zeroed history.
        check("reset z_zero", {31'd0, z_w[2]}, 32'd0);
        check("reset z_q_def", {31'd0, z_q_w[0]}, 32'd0);
        check("reset cnt_def", {24'd0, cnt_w[0]}, 32'd0);
        @(negedge Clock);
        Reset_n = 1'b1;

        // Overlapping detection of 0110 in 0110110.
        run_seq(0, 7, 32'b0110110, 32'b0001001, "ovl");
        check("ovl cnt", {24'd0, cnt_w[0]}, exp_cnt(2));

        do_reset();
        run_seq(1, 11, 32'b01101100110, 32'b00010000001, "novl");
        check("novl cnt", {24'd0, cnt_w[1]}, exp_cnt(2));

        do_reset();
        run_seq(2, 5, 32'b00000, 32'b00011, "zeros");
        check("zeros cnt", {24'd0, cnt_w[2]}, exp_cnt(2));

        // Idle cycles with en=0 must neither advance history nor flag a match.
        do_reset();
        apply(0, 1'b1, 1'b0, 1'b0, 1'b0, "gap b1");
        apply(0, 1'b1, 1'b1, 1'b0, 1'b0, "gap b2");
        for (int i = 0; i < 3; i++) begin
            apply(0, 1'b0, 1'b1, 1'b0, 1'b0, $sformatf("gap idle%0d", i));
        end
        apply(0, 1'b1, 1'b1, 1'b0, 1'b0, "gap b3");
        apply(0, 1'b1, 1'b0, 1'b0, 1'b1, "gap b4");
        check("gap cnt", {24'd0, cnt_w[0]}, exp_cnt(1));

        // Asynchronous reset pulse between edges, mid-pattern.
        apply(0, 1'b1, 1'b0, 1'b0, 1'b0, "arst b1");
        apply(0, 1'b1, 1'b1, 1'b0, 1'b0, "arst b2");
        apply(0, 1'b1, 1'b1, 1'b0, 1'b0, "arst b3");
        #1;
        en = 1'b1;
        x  = 1'b0;
        Reset_n = 1'b0;
        #1;
        check("arst z_during", {31'd0, z_w[0]}, 32'd0);
        check("arst cnt_during", {24'd0, cnt_w[0]}, 32'd0);
        check("arst z_q_during", {31'd0, z_q_w[0]}, 32'd0);
        #1;
        Reset_n = 1'b1;
        apply(0, 1'b1, 1'b0, 1'b0, 1'b0, "arst b4");
        check("arst cnt", {24'd0, cnt_w[0]}, 32'd0);

        // Saturation of a 2-bit counter, then clear coinciding with a match.
        do_reset();
        run_seq(3, 10, 32'b0110110110, 32'b0001001001, "sat a");
        check("sat cnt3", {24'd0, cnt_w[3]}, exp_cnt(3));
        run_seq(3, 6, 32'b110110, 32'b001001, "sat b");
        check("sat cnt5", {24'd0, cnt_w[3]}, exp_cnt(3));
        apply(3, 1'b1, 1'b1, 1'b0, 1'b0, "sat c1");
        apply(3, 1'b1, 1'b1, 1'b0, 1'b0, "sat c2");
        apply(3, 1'b1, 1'b0, 1'b1, 1'b1, "sat c3");
        check("sat clr", {24'd0, cnt_w[3]}, 32'd0);
        clr = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
